maxpool_2x2_stream: RTL and testbench

- 2x2 stride-2 max-pooling stage for the streaming CNN pipeline.
- Consumes one multi-unit pixel per enabled cycle in raster order with its coordinates, and emits one pooled pixel per 2x2 window with halved coordinates.
- Its output stream is the reduced-resolution stream that the upsampling (unpooling) stage later restores to full resolution.
- Uses a half-width row buffer and carries no backpressure.

---
 rtl/maxpool_2x2_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_maxpool_2x2_stream.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 signed max-pooling over a raster pixel stream, no backpressure.
// Define MAXPOOL_ARGMAX_EN to add out_index, a 2-bit window winner per unit.
module maxpool_2x2_stream #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIXED_BITW = 16,
    parameter int UNITS      = 8,
    localparam int V_BITW    = $clog2(HEIGHT),
    localparam int H_BITW    = $clog2(WIDTH),
    localparam int PIX_W     = FIXED_BITW * UNITS
) (
    input  logic               clock,
    input  logic               n_rst,
    input  logic               in_enable,
    input  logic [PIX_W-1:0]   in_pixels,
    input  logic [V_BITW-1:0]  in_vcnt,
    input  logic [H_BITW-1:0]  in_hcnt,
`ifdef MAXPOOL_ARGMAX_EN
    output logic [2*UNITS-1:0] out_index,
`endif
    output logic               out_enable,
    output logic [PIX_W-1:0]   out_pixels,
    output logic [V_BITW-2:0]  out_vcnt,
    output logic [H_BITW-2:0]  out_hcnt
);
    localparam int HALF = WIDTH / 2;
    localparam int A_W  = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {P_EMPTY, P_HELD} pair_e;

    logic              in_en_q, in_en_d;
    logic [PIX_W-1:0]  in_pix_q, in_pix_d;
    logic [V_BITW-1:0] in_v_q, in_v_d;
    logic [H_BITW-1:0] in_h_q, in_h_d;

    pair_e             pair_q, pair_d;
    logic [PIX_W-1:0]  left_q, left_d;
    logic [H_BITW-1:0] left_h_q, left_h_d;
    logic              hmax_vld;
    logic [PIX_W-1:0]  hmax;

    logic              s1_vld_q, s1_vld_d;
    logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;
    logic              s1_odd_q, s1_odd_d;
    logic [V_BITW-2:0] s1_v_q, s1_v_d;
    logic [H_BITW-2:0] s1_a_q, s1_a_d;

    logic [HALF-1:0]   row_vld_q, row_vld_d;
    logic [PIX_W-1:0]  row_pix [HALF];
    logic [A_W-1:0]    addr;
    logic              a_ok;
    logic [PIX_W-1:0]  rd_pix;
    logic [PIX_W-1:0]  vmax;

    logic              out_en_q, out_en_d;
    logic [PIX_W-1:0]  out_pix_q, out_pix_d;
    logic [V_BITW-2:0] out_v_q, out_v_d;
    logic [H_BITW-2:0] out_h_q, out_h_d;

`ifdef MAXPOOL_ARGMAX_EN
    logic [UNITS-1:0]   hsel;
    logic [UNITS-1:0]   s1_sel_q, s1_sel_d;
    logic [UNITS-1:0]   row_sel [HALF];
    logic [UNITS-1:0]   rd_sel;
    logic [UNITS-1:0]   vsel;
    logic [2*UNITS-1:0] out_idx_q, out_idx_d;
`endif

    // Capture the incoming stream so pairing works from a registered pixel.
    always_comb begin
        in_en_d  = in_enable;
        in_pix_d = in_pixels;
        in_v_d   = in_vcnt;
        in_h_d   = in_hcnt;
    end

    // Horizontal pair tracking; the left pixel wins ties.
    always_comb begin
        pair_d   = pair_q;
        left_d   = left_q;
        left_h_d = left_h_q;
        hmax_vld = 1'b0;
        hmax     = left_q;
`ifdef MAXPOOL_ARGMAX_EN
        hsel     = '0;
`endif
        if (in_en_q) begin
            if (!in_h_q[0]) begin
                pair_d   = P_HELD;
                left_d   = in_pix_q;
                left_h_d = in_h_q;
            end else begin
                pair_d   = P_EMPTY;
                hmax_vld = (pair_q == P_HELD) &&
                           (in_h_q == left_h_q + H_BITW'(1));
            end
        end
        for (int u = 0; u < UNITS; u++) begin
            if ($signed(in_pix_q[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW]) >
                $signed(left_q[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW])) begin
                hmax[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW] =
                    in_pix_q[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW];
`ifdef MAXPOOL_ARGMAX_EN
                hsel[u] = 1'b1;
`endif
            end
        end
    end

    // Stage 1 holds the horizontal max with its row parity and coordinates.
    always_comb begin
        s1_vld_d = hmax_vld;
        s1_pix_d = hmax;
        s1_odd_d = in_v_q[0];
        s1_v_d   = in_v_q[V_BITW-1:1];
        s1_a_d   = in_h_q[H_BITW-1:1];
`ifdef MAXPOOL_ARGMAX_EN
        s1_sel_d = hsel;
`endif
    end

    assign addr   = s1_a_q[A_W-1:0];
    assign a_ok   = (int'(s1_a_q) < HALF);
    assign rd_pix = row_pix[addr];
`ifdef MAXPOOL_ARGMAX_EN
    assign rd_sel = row_sel[addr];
`endif

    // Stage 2 pairs odd-line maxima with the buffered even line; upper wins ties.
    always_comb begin
        row_vld_d = row_vld_q;
        out_en_d  = 1'b0;
        out_pix_d = out_pix_q;
        out_v_d   = out_v_q;
        out_h_d   = out_h_q;
        vmax      = rd_pix;
`ifdef MAXPOOL_ARGMAX_EN
        vsel      = '0;
        out_idx_d = out_idx_q;
`endif
        for (int u = 0; u < UNITS; u++) begin
            if ($signed(s1_pix_q[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW]) >
                $signed(rd_pix[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW])) begin
                vmax[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW] =
                    s1_pix_q[(UNITS-1-u)*FIXED_BITW +: FIXED_BITW];
`ifdef MAXPOOL_ARGMAX_EN
                vsel[u] = 1'b1;
`endif
            end
        end
        if (s1_vld_q && a_ok) begin
            if (!s1_odd_q) begin
                row_vld_d[addr] = 1'b1;
            end else if (row_vld_q[addr]) begin
                row_vld_d[addr] = 1'b0;
                out_en_d        = 1'b1;
                out_pix_d       = vmax;
                out_v_d         = s1_v_q;
                out_h_d         = s1_a_q;
`ifdef MAXPOOL_ARGMAX_EN
                for (int u = 0; u < UNITS; u++) begin
                    out_idx_d[(UNITS-1-u)*2 +: 2] =
                        {vsel[u], vsel[u] ? s1_sel_q[u] : rd_sel[u]};
                end
`endif
            end
        end
    end

    // Even-line horizontal maxima storage; validity is tracked separately.
    always_ff @(posedge clock) begin
        if (s1_vld_q && !s1_odd_q && a_ok) begin
            row_pix[addr] <= s1_pix_q;
`ifdef MAXPOOL_ARGMAX_EN
            row_sel[addr] <= s1_sel_q;
`endif
        end
    end

    // All control and output state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            in_en_q   <= 1'b0;
            in_pix_q  <= '0;
            in_v_q    <= '0;
            in_h_q    <= '0;
            pair_q    <= P_EMPTY;
            left_q    <= '0;
            left_h_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_pix_q  <= '0;
            s1_odd_q  <= 1'b0;
            s1_v_q    <= '0;
            s1_a_q    <= '0;
            row_vld_q <= '0;
            out_en_q  <= 1'b0;
            out_pix_q <= '0;
            out_v_q   <= '0;
            out_h_q   <= '0;
`ifdef MAXPOOL_ARGMAX_EN
            s1_sel_q  <= '0;
            out_idx_q <= '0;
`endif
        end else begin
            in_en_q   <= in_en_d;
            in_pix_q  <= in_pix_d;
            in_v_q    <= in_v_d;
            in_h_q    <= in_h_d;
            pair_q    <= pair_d;
            left_q    <= left_d;
            left_h_q  <= left_h_d;
            s1_vld_q  <= s1_vld_d;
            s1_pix_q  <= s1_pix_d;
            s1_odd_q  <= s1_odd_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            row_vld_q <= row_vld_d;
            out_en_q  <= out_en_d;
            out_pix_q <= out_pix_d;
            out_v_q   <= out_v_d;
            out_h_q   <= out_h_d;
`ifdef MAXPOOL_ARGMAX_EN
            s1_sel_q  <= s1_sel_d;
            out_idx_q <= out_idx_d;
`endif
        end
    end

    assign out_enable = out_en_q;
    assign out_pixels = out_pix_q;
    assign out_vcnt   = out_v_q;
    assign out_hcnt   = out_h_q;
`ifdef MAXPOOL_ARGMAX_EN
    assign out_index  = out_idx_q;
`endif

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: directed windows plus random frames
// checked against a frame-array window-max model.
module tb_maxpool_2x2_stream;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  v;
        logic [7:0]  h;
        logic [31:0] pix;
        logic [3:0]  idx;
    } rec_t;

    logic        clock;
    logic        n_rst;
    logic        in_en;
    logic [31:0] in_pix;
    logic [3:0]  in_v;
    logic [4:0]  in_h;

    logic        m_en;
    logic [31:0] m_pix;
    logic [2:0]  m_v;
    logic [3:0]  m_h;
    logic [3:0]  m_idx;

    logic        o_en;
    logic [31:0] o_pix;
    logic [0:0]  o_v;
    logic [1:0]  o_h;
    logic [3:0]  o_idx;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   fr [0:15][0:31][0:1];
    rec_t got_q [$];
    rec_t exp_q [$];
    rec_t o_q [$];

    maxpool_2x2_stream #(
        .WIDTH(32), .HEIGHT(16), .FIXED_BITW(16), .UNITS(2)
    ) dut_m (
        .clock(clock), .n_rst(n_rst),
        .in_enable(in_en), .in_pixels(in_pix),
        .in_vcnt(in_v), .in_hcnt(in_h),
`ifdef MAXPOOL_ARGMAX_EN
        .out_index(m_idx),
`endif
        .out_enable(m_en), .out_pixels(m_pix),
        .out_vcnt(m_v), .out_hcnt(m_h)
    );

    maxpool_2x2_stream #(
        .WIDTH(5), .HEIGHT(3), .FIXED_BITW(16), .UNITS(2)
    ) dut_o (
        .clock(clock), .n_rst(n_rst),
        .in_enable(in_en), .in_pixels(in_pix),
        .in_vcnt(in_v[1:0]), .in_hcnt(in_h[2:0]),
`ifdef MAXPOOL_ARGMAX_EN
        .out_index(o_idx),
`endif
        .out_enable(o_en), .out_pixels(o_pix),
        .out_vcnt(o_v), .out_hcnt(o_h)
    );

`ifndef MAXPOOL_ARGMAX_EN
    assign m_idx = 4'd0;
    assign o_idx = 4'd0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Collect output pulses at the falling edge, stamped with the cycle number.
    initial begin
        rec_t r;
        cyc = 0;
        forever begin
            @(negedge clock);
            if (m_en === 1'b1) begin
                r.cyc = cyc; r.v = 8'(m_v); r.h = 8'(m_h);
                r.pix = m_pix; r.idx = m_idx;
                got_q.push_back(r);
            end
            if (o_en === 1'b1) begin
                r.cyc = cyc; r.v = 8'(o_v); r.h = 8'(o_h);
                r.pix = o_pix; r.idx = o_idx;
                o_q.push_back(r);
            end
            cyc = cyc + 1;
        end
    end

    task automatic idle(input int n);
        in_en = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] p, input int y, input int x,
                        output int sc);
        in_en  = 1'b1;
        in_pix = p;
        in_v   = y[3:0];
        in_h   = x[4:0];
        @(posedge clock);
        sc = cyc;
        #1;
        in_en = 1'b0;
    endtask

    function automatic logic [31:0] pack(input int y, input int x);
        return {16'(fr[y][x][0]), 16'(fr[y][x][1])};
    endfunction

    // Window max over the four pixels, scanning UL,UR,LL,LR; first max wins.
    function automatic rec_t window(input int y2, input int x2, input int c);
        rec_t r;
        int   best;
        int   bi;
        int   val;
        r.cyc = c; r.v = 8'(y2); r.h = 8'(x2);
        r.pix = '0; r.idx = '0;
        for (int u = 0; u < 2; u++) begin
            best = fr[2*y2][2*x2][u];
            bi   = 0;
            for (int k = 1; k < 4; k++) begin
                val = fr[2*y2 + k/2][2*x2 + k%2][u];
                if (val > best) begin
                    best = val;
                    bi   = k;
                end
            end
            r.pix[(1-u)*16 +: 16] = 16'(best);
`ifdef MAXPOOL_ARGMAX_EN
            r.idx[(1-u)*2 +: 2] = 2'(bi);
`endif
        end
        return r;
    endfunction

    // Raster feed of a w x h frame; gap<0 gives random 0..2 idle cycles.
    task automatic feed_frame(input int w, input int h, input int gap);
        int sc;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                send(pack(y, x), y, x, sc);
                if ((y % 2 == 1) && (x % 2 == 1))
                    exp_q.push_back(window(y/2, x/2, sc + 2));
                if (gap < 0) idle(int'($urandom_range(0, 2)));
                else if (gap > 0) idle(gap);
            end
        end
    endtask

    task automatic fill_rand();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 32; x++)
                for (int u = 0; u < 2; u++)
                    if ($urandom_range(0, 1) == 1)
                        fr[y][x][u] = int'($urandom_range(0, 65535)) - 32768;
                    else
                        fr[y][x][u] = int'($urandom_range(0, 4)) - 2;
    endtask

    task automatic set_scenario1();
        int r0 [4] = '{1, 5, 2, 3};
        int r1 [4] = '{4, 0, 7, -8};
        for (int x = 0; x < 4; x++) begin
            fr[0][x][0] = r0[x];
            fr[1][x][0] = r1[x];
            fr[0][x][1] = 32767;
            fr[1][x][1] = 32767;
        end
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        @(posedge clock);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) begin
            in_en  = 1'($urandom_range(0, 1));
            in_pix = $urandom;
            in_v   = 4'($urandom);
            in_h   = 5'($urandom);
            @(posedge clock);
            #1;
        end
        n_cmp++;
        if ({m_en, m_pix, m_v, m_h, m_idx} !== 44'd0) begin
            n_bad++;
            $display("FAIL reset_m: got en%b p%h v%h h%h i%h want all 0",
                     m_en, m_pix, m_v, m_h, m_idx);
        end
        n_cmp++;
        if ({o_en, o_pix, o_v, o_h, o_idx} !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_o: got en%b p%h v%h h%h want all 0",
                     o_en, o_pix, o_v, o_h);
        end
        n_rst = 1'b1;
        idle(2);
        got_q.delete(); o_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic();
        rec_t last;
        set_scenario1();
        feed_frame(4, 2, 0);
        idle(4);
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 2", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0].pix !== 32'h0005_7FFF || got_q[0].h !== 8'd0) begin
                n_bad++;
                $display("FAIL basic_w0: got %h h%0d want 00057fff h0",
                         got_q[0].pix, got_q[0].h);
            end
            n_cmp++;
            if (got_q[1].pix !== 32'h0007_7FFF || got_q[1].h !== 8'd1) begin
                n_bad++;
                $display("FAIL basic_w1: got %h h%0d want 00077fff h1",
                         got_q[1].pix, got_q[1].h);
            end
`ifdef MAXPOOL_ARGMAX_EN
            n_cmp++;
            if (got_q[0].idx !== 4'b0100 || got_q[1].idx !== 4'b1000) begin
                n_bad++;
                $display("FAIL basic_idx: got %b %b want 0100 1000",
                         got_q[0].idx, got_q[1].idx);
            end
`endif
        end
        last = exp_q[exp_q.size()-1];
        n_cmp++;
        if (m_en !== 1'b0 || m_pix !== last.pix || 8'(m_h) !== last.h) begin
            n_bad++;
            $display("FAIL basic_hold: got en%b %h h%0d want en0 %h h%0d",
                     m_en, m_pix, m_h, last.pix, last.h);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL basic[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_signed();
        int a [4] = '{-3, -9, -1, -2};
        for (int k = 0; k < 4; k++) begin
            fr[k/2][k%2][0] = a[k];
            fr[k/2][k%2][1] = 32767;
        end
        feed_frame(2, 2, 0);
        idle(4);
        n_cmp++;
        if (got_q.size() != 1) begin
            n_bad++;
            $display("FAIL signed_count: got %0d want 1", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0].pix !== 32'hFFFF_7FFF) begin
                n_bad++;
                $display("FAIL signed_max: got %h want ffff7fff", got_q[0].pix);
            end
`ifdef MAXPOOL_ARGMAX_EN
            n_cmp++;
            if (got_q[0].idx !== 4'b1000) begin
                n_bad++;
                $display("FAIL signed_idx: got %b want 1000", got_q[0].idx);
            end
`endif
            n_cmp++;
            if (got_q[0] !== exp_q[0]) begin
                n_bad++;
                $display("FAIL signed_rec: got %h want %h", got_q[0], exp_q[0]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_gaps();
        set_scenario1();
        feed_frame(4, 2, 3);
        idle(4);
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL gaps_count: got %0d want 2", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL gaps[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int sc;
        fill_rand();
        for (int x = 0; x < 4; x++) send(pack(0, x), 0, x, sc);
        pulse_reset();
        n_cmp++;
        if ({m_en, m_pix, m_v, m_h, m_idx} !== 44'd0) begin
            n_bad++;
            $display("FAIL rstmid_out: got en%b p%h v%h h%h want all 0",
                     m_en, m_pix, m_v, m_h);
        end
        for (int x = 0; x < 4; x++) send(pack(1, x), 1, x, sc);
        idle(4);
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_none: got %0d pulses want 0", got_q.size());
        end
        got_q.delete();
        fill_rand();
        feed_frame(4, 4, 0);
        idle(4);
        n_cmp++;
        if (got_q.size() != 4) begin
            n_bad++;
            $display("FAIL rstmid_count: got %0d want 4", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rstmid[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_odd_size();
        pulse_reset();
        idle(2);
        got_q.delete(); o_q.delete(); exp_q.delete();
        fill_rand();
        feed_frame(5, 3, 0);
        idle(4);
        n_cmp++;
        if (o_q.size() != 2) begin
            n_bad++;
            $display("FAIL odd_o_count: got %0d want 2", o_q.size());
        end
        foreach (exp_q[i]) if (i < o_q.size()) begin
            n_cmp++;
            if (o_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL odd_o[%0d]: got %h want %h", i, o_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL odd_m_count: got %0d want 2", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL odd_m[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete(); o_q.delete();
    endtask

    task automatic test_back_to_back();
        fill_rand();
        feed_frame(32, 16, 0);
        fill_rand();
        feed_frame(32, 16, -1);
        fill_rand();
        feed_frame(32, 16, 0);
        idle(4);
        n_cmp++;
        if (got_q.size() != 3 * 128) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 3 * 128);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        n_rst  = 1'b0;
        in_en  = 1'b0;
        in_pix = '0;
        in_v   = '0;
        in_h   = '0;
        #1;
        test_reset();
        test_basic();
        test_signed();
        test_gaps();
        test_reset_mid();
        test_odd_size();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
